// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle game core.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2,
        WIN  = 2'd3
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Obstacle height in pixels for a slot's tall flag.
    function automatic logic [9:0] obst_height(input logic       tall,
                                               input logic [9:0] short_h,
                                               input logic [9:0] tall_h);
        return tall ? tall_h : short_h;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used for obstacle type and spawn spacing.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    // Shift right, folding the tap mask in whenever a one drops out.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every register samples pre-edge values.
        if (reset)
            value <= LFSR_SEED;
        else if (enable)
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/obstacle_engine.sv
// Game core: MENU/PLAY/DEAD/WIN control, tick divider, obstacle slots,
// collision, scoring and speed ramp.
module obstacle_engine
    import game_pkg::*;
#(
    parameter int NUM_OBST       = 8,
    parameter int X_W            = 10,
    parameter int SCORE_W        = 8,
    parameter int TICK_DIV       = 2_083_333,
    parameter int SCREEN_W       = 640,
    parameter int PLAYER_X       = 64,
    parameter int PLAYER_W       = 16,
    parameter int OBST_W         = 16,
    parameter int SHORT_H        = 20,
    parameter int TALL_H         = 40,
    parameter int MIN_GAP        = 12,
    parameter int GAP_MASK       = 15,
    parameter int SPEED_INIT     = 2,
    parameter int SPEED_MAX      = 8,
    parameter int SPEED_STEP_PTS = 10,
    parameter int WIN_SCORE      = 100
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [9:0]              player_y,
    output logic                    game_tick,
    output logic [1:0]              state,
    output logic [NUM_OBST-1:0]     obst_valid,
    output logic [NUM_OBST-1:0]     obst_tall,
    output logic [NUM_OBST*X_W-1:0] obst_x,
    output logic [SCORE_W-1:0]      score,
    output logic [3:0]              speed
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W = (MIN_GAP + GAP_MASK > 0) ? $clog2(MIN_GAP + GAP_MASK + 1) : 1;
    localparam int CNT_W = $clog2(NUM_OBST + 1);
    localparam int SUM_W = SCORE_W + 5;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [X_W:0]     HIT_HI   = (X_W + 1)'(PLAYER_X + PLAYER_W);
    localparam logic [X_W:0]     HIT_LO   = (X_W + 1)'(PLAYER_X);
    localparam logic [X_W:0]     OBST_WX  = (X_W + 1)'(OBST_W);
    localparam logic [X_W-1:0]   SPAWN_X  = X_W'(SCREEN_W - 1);
    localparam logic [SUM_W-1:0] STEP     = SUM_W'(SPEED_STEP_PTS);

    game_state_t         state_q;
    logic [DIV_W-1:0]    div_cnt, div_next;
    logic [GAP_W-1:0]    gap_q, gap_reload;
    logic [SCORE_W-1:0]  score_q;
    logic [3:0]          speed_q;
    logic [15:0]         lfsr_val;
    logic                unused_lfsr_bits;

    logic [NUM_OBST-1:0] hit_vec, clr_vec, free_vec, spawn_sel;
    logic [CNT_W-1:0]    clr_count;
    logic [SUM_W-1:0]    score_sum;
    logic                tick_play, hit, advance, win_now, spawn_any, spawn_ok;
    logic                step_cross, clear_game;

    assign state = state_q;
    assign score = score_q;
    assign speed = speed_q;

    lfsr16 u_lfsr (
        .clk    (CLOCK_50),
        .reset  (reset),
        .enable (1'b1),
        .value  (lfsr_val)
    );

    assign unused_lfsr_bits = ^{lfsr_val[15:8], lfsr_val[3:1]};
    assign gap_reload = GAP_W'(MIN_GAP) + GAP_W'(lfsr_val[7:4] & 4'(GAP_MASK));

    // Free-running tick divider; game_tick is registered so it lines up with the terminal count.
    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt   <= '0;
            game_tick <= 1'b0;
        end else begin
            div_cnt   <= div_next;
            game_tick <= (div_next == DIV_LAST);
        end
    end

    // Control terms evaluated on registered slot state.
    assign tick_play  = game_tick && (state_q == PLAY);
    assign hit        = |hit_vec;
    assign advance    = tick_play && !hit;
    assign free_vec   = ~obst_valid | clr_vec;
    assign spawn_any  = |free_vec;
    assign score_sum  = SUM_W'(score_q) + SUM_W'(clr_count);
    assign win_now    = score_sum >= SUM_W'(WIN_SCORE);
    assign spawn_ok   = advance && !win_now && (gap_q == '0) && spawn_any;
    assign step_cross = (score_sum / STEP) != (SUM_W'(score_q) / STEP);
    assign clear_game = (state_q == MENU) ||
                        (((state_q == DEAD) || (state_q == WIN)) && start);

    // Count slots leaving the screen and pick the lowest free slot for spawning.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned and infers a latch.
        clr_count = '0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_OBST; i++)
            clr_count = clr_count + CNT_W'(clr_vec[i]);
        for (int i = NUM_OBST - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                spawn_sel    = '0;
                spawn_sel[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_OBST; i++) begin : gen_slot
        logic           valid_r, tall_r;
        logic [X_W-1:0] x_r;

        assign obst_valid[i]            = valid_r;
        assign obst_tall[i]             = tall_r;
        assign obst_x[i*X_W +: X_W]     = x_r;

        assign hit_vec[i] = valid_r &&
                            ({1'b0, x_r} < HIT_HI) &&
                            (({1'b0, x_r} + OBST_WX) > HIT_LO) &&
                            (player_y < obst_height(tall_r, 10'(SHORT_H), 10'(TALL_H)));
        assign clr_vec[i] = valid_r && (x_r < X_W'(speed_q));

        // Slot register: spawn, scroll off, or move left by the current speed.
        always_ff @(posedge CLOCK_50) begin
            if (reset || clear_game) begin
                valid_r <= 1'b0;
                tall_r  <= 1'b0;
                x_r     <= '0;
            end else if (advance) begin
                if (spawn_ok && spawn_sel[i]) begin
                    valid_r <= 1'b1;
                    tall_r  <= lfsr_val[0];
                    x_r     <= SPAWN_X;
                end else if (clr_vec[i]) begin
                    valid_r <= 1'b0;
                    x_r     <= '0;
                end else if (valid_r) begin
                    x_r     <= x_r - X_W'(speed_q);
                end
            end
        end
    end

    // Game FSM with score, speed ramp and spawn spacing counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= MENU;
            score_q <= '0;
            speed_q <= 4'(SPEED_INIT);
            gap_q   <= GAP_W'(MIN_GAP);
        end else begin
            unique case (state_q)
                MENU: if (start) state_q <= PLAY;
                PLAY: begin
                    if (tick_play) begin
                        if (hit) begin
                            state_q <= DEAD;
                        end else begin
                            score_q <= score_sum[SCORE_W-1:0];
                            if (step_cross && (speed_q < 4'(SPEED_MAX)))
                                speed_q <= speed_q + 4'd1;
                            if (win_now)
                                state_q <= WIN;
                            else if (gap_q != '0)
                                gap_q <= gap_q - 1'b1;
                            else if (spawn_any)
                                gap_q <= gap_reload;
                        end
                    end
                end
                DEAD, WIN: if (start) state_q <= MENU;
            endcase
            if (clear_game) begin
                score_q <= '0;
                speed_q <= 4'(SPEED_INIT);
                gap_q   <= GAP_W'(MIN_GAP);
            end
        end
    end

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench: dut_a exercises spawning, scrolling and the speed ramp;
// dut_b (WIN_SCORE=3, PLAYER_X=0) exercises collision, win and reset.
module tb_obstacle_engine;

    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, start_a, reset_b, start_b;
    logic [9:0]  y_a, y_b;
    logic        tick_a, tick_b;
    logic [1:0]  state_a, state_b, valid_a, valid_b, tall_a, tall_b;
    logic [19:0] x_a, x_b;
    logic [7:0]  score_a, score_b;
    logic [3:0]  speed_a, speed_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ref_lfsr_a, tick_lfsr_a;

    obstacle_engine #(.NUM_OBST(2), .TICK_DIV(TICK_DIV), .MIN_GAP(2), .GAP_MASK(0)) dut_a (
        .CLOCK_50(clk), .reset(reset_a), .start(start_a), .player_y(y_a),
        .game_tick(tick_a), .state(state_a), .obst_valid(valid_a), .obst_tall(tall_a),
        .obst_x(x_a), .score(score_a), .speed(speed_a)
    );

    obstacle_engine #(.NUM_OBST(2), .TICK_DIV(TICK_DIV), .MIN_GAP(2), .GAP_MASK(0),
                      .WIN_SCORE(3), .PLAYER_X(0)) dut_b (
        .CLOCK_50(clk), .reset(reset_b), .start(start_b), .player_y(y_b),
        .game_tick(tick_b), .state(state_b), .obst_valid(valid_b), .obst_tall(tall_b),
        .obst_x(x_b), .score(score_b), .speed(speed_b)
    );

    // Reference Galois LFSR for dut_a, seeded 0xACE1 with taps 0xB400.
    always @(posedge clk) begin
        if (reset_a) ref_lfsr_a <= 16'hACE1;
        else         ref_lfsr_a <= {1'b0, ref_lfsr_a[15:1]} ^ (ref_lfsr_a[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the cycle after the next game tick of the selected DUT.
    task automatic next_tick(input bit sel);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            if ((sel ? tick_b : tick_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (seen) tick_lfsr_a = ref_lfsr_a;
        else      check("tick_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks, last, bad, guard, exp_speed;
        logic [7:0] prev;

        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        y_a = 10'd100; y_b = 10'd40;
        repeat (3) @(negedge clk);

        check("rst_state",  32'(state_a), 32'd0);
        check("rst_valid",  32'(valid_a), 32'd0);
        check("rst_x",      32'(x_a),     32'd0);
        check("rst_score",  32'(score_a), 32'd0);
        check("rst_speed",  32'(speed_a), 32'd2);
        check("rst_tick",   32'(tick_a),  32'd0);
        reset_a = 1'b0; reset_b = 1'b0;

        // MENU idle: ticks every 4 cycles, nothing moves.
        ticks = 0; last = -1; bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tick_a) begin
                if (last >= 0 && c - last != 4) bad++;
                last = c;
                ticks++;
            end
        end
        check("menu_tick_count",  32'(ticks),   32'd10);
        check("menu_tick_period", 32'(bad),     32'd0);
        check("menu_state",       32'(state_a), 32'd0);
        check("menu_valid",       32'(valid_a), 32'd0);

        // PLAY: first spawn on tick 3, then 2 px per tick.
        pulse_start(1'b0);
        check("a_play",        32'(state_a), 32'd1);
        check("a_play_valid",  32'(valid_a), 32'd0);
        next_tick(1'b0); next_tick(1'b0);
        check("a_t2_nospawn",  32'(valid_a), 32'd0);
        next_tick(1'b0);
        check("a_t3_valid",    32'(valid_a),    32'd1);
        check("a_t3_x0",       32'(x_a[9:0]),   32'd639);
        check("a_t3_tall0",    32'(tall_a[0]),  32'(tick_lfsr_a[0]));
        next_tick(1'b0);
        check("a_t4_x0",       32'(x_a[9:0]),   32'd637);
        next_tick(1'b0); next_tick(1'b0);
        check("a_t6_valid",    32'(valid_a),    32'd3);
        check("a_t6_x0",       32'(x_a[9:0]),   32'd633);
        check("a_t6_x1",       32'(x_a[19:10]), 32'd639);
        repeat (3) next_tick(1'b0);
        check("a_t9_full_valid", 32'(valid_a),    32'd3);
        check("a_t9_x0",         32'(x_a[9:0]),   32'd627);
        check("a_t9_x1",         32'(x_a[19:10]), 32'd633);

        pulse_start(1'b0);
        check("a_start_ignored", 32'(state_a), 32'd1);

        repeat (313) next_tick(1'b0);
        check("a_t322_x0",    32'(x_a[9:0]),   32'd1);
        check("a_t322_x1",    32'(x_a[19:10]), 32'd7);
        check("a_t322_score", 32'(score_a),    32'd0);
        next_tick(1'b0);
        check("a_t323_valid", 32'(valid_a),    32'd3);
        check("a_t323_x0",    32'(x_a[9:0]),   32'd639);
        check("a_t323_x1",    32'(x_a[19:10]), 32'd5);
        check("a_t323_score", 32'(score_a),    32'd1);
        check("a_t323_tall0", 32'(tall_a[0]),  32'(tick_lfsr_a[0]));

        // Speed ramp: +1 per 10 points, saturating at 8.
        prev = score_a; guard = 0;
        while (score_a < 8'd70 && guard < 9000) begin
            next_tick(1'b0);
            guard++;
            if (score_a != prev) begin
                exp_speed = 2 + int'(score_a) / 10;
                if (exp_speed > 8) exp_speed = 8;
                check("a_speed_vs_score", 32'(speed_a), 32'(exp_speed));
                prev = score_a;
            end
        end
        check("a_score_70_reached", 32'(score_a >= 8'd70), 32'd1);
        check("a_speed_sat",        32'(speed_a),          32'd8);
        check("a_still_play",       32'(state_a),          32'd1);

        // dut_b game 1: y=40 never hits (not below height), then x boundary.
        pulse_start(1'b1);
        repeat (314) next_tick(1'b1);
        check("b1_x0_17", 32'(x_b[9:0]), 32'd17);
        y_b = 10'd0;
        next_tick(1'b1);
        check("b1_x17_nohit", 32'(state_b),  32'd1);
        check("b1_x0_15",     32'(x_b[9:0]), 32'd15);
        next_tick(1'b1);
        check("b1_dead",      32'(state_b),     32'd2);
        check("b1_dead_x0",   32'(x_b[9:0]),    32'd15);
        check("b1_dead_x1",   32'(x_b[19:10]),  32'd21);
        next_tick(1'b1);
        check("b1_frozen_x0", 32'(x_b[9:0]),    32'd15);
        check("b1_frozen_st", 32'(state_b),     32'd2);
        pulse_start(1'b1);
        check("b1_menu",       32'(state_b), 32'd0);
        check("b1_menu_score", 32'(score_b), 32'd0);
        check("b1_menu_valid", 32'(valid_b), 32'd0);
        check("b1_menu_speed", 32'(speed_b), 32'd2);

        // Game 2: start lands on a MENU tick; collision on the 3rd-clear tick wins over WIN.
        y_b = 10'd40;
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            @(negedge clk);
            if (tick_b) break;
        end
        check("b2_start_on_tick", 32'(tick_b), 32'd1);
        pulse_start(1'b1);
        check("b2_play",       32'(state_b), 32'd1);
        check("b2_play_valid", 32'(valid_b), 32'd0);
        repeat (642) next_tick(1'b1);
        check("b2_t642_score", 32'(score_b),     32'd2);
        check("b2_t642_x0",    32'(x_b[9:0]),    32'd1);
        check("b2_t642_x1",    32'(x_b[19:10]),  32'd7);
        y_b = 10'd0;
        next_tick(1'b1);
        check("b2_hit_over_win", 32'(state_b),  32'd2);
        check("b2_hit_score",    32'(score_b),  32'd2);
        check("b2_hit_valid",    32'(valid_b),  32'd3);
        check("b2_hit_x0",       32'(x_b[9:0]), 32'd1);
        pulse_start(1'b1);
        check("b2_menu", 32'(state_b), 32'd0);

        // Game 3: same tick without collision reaches WIN; slots hold.
        y_b = 10'd40;
        pulse_start(1'b1);
        repeat (643) next_tick(1'b1);
        check("b3_win",       32'(state_b),    32'd3);
        check("b3_win_score", 32'(score_b),    32'd3);
        check("b3_win_valid", 32'(valid_b),    32'd2);
        check("b3_win_x1",    32'(x_b[19:10]), 32'd5);
        next_tick(1'b1); next_tick(1'b1);
        check("b3_hold_state", 32'(state_b),    32'd3);
        check("b3_hold_x1",    32'(x_b[19:10]), 32'd5);
        check("b3_hold_valid", 32'(valid_b),    32'd2);

        // Reset in WIN: reset values next cycle, divider restarts at 0.
        reset_b = 1'b1;
        @(negedge clk);
        check("b_rst_state", 32'(state_b), 32'd0);
        check("b_rst_valid", 32'(valid_b), 32'd0);
        check("b_rst_tall",  32'(tall_b),  32'd0);
        check("b_rst_x",     32'(x_b),     32'd0);
        check("b_rst_score", 32'(score_b), 32'd0);
        check("b_rst_speed", 32'(speed_b), 32'd2);
        check("b_rst_tick",  32'(tick_b),  32'd0);
        reset_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_div_cnt2_tick", 32'(tick_b), 32'd0);
        @(negedge clk);
        check("b_div_cnt3_tick", 32'(tick_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
